// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Shares one APB3 master port between NREQ single-word requesters.
// Round-robin arbitration, one complete SETUP/ACCESS transfer per grant,
// PSEL decoded from address bits [27:24], and a PREADY-low timeout that
// aborts a transfer to a hung slave with an error completion.
module apb_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               i_pclk,
    input  logic               i_preset,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_req_write,
    input  logic [32*NREQ-1:0] i_req_addr,
    input  logic [32*NREQ-1:0] i_req_wdata,
    output logic [NREQ-1:0]    o_grant,
    output logic [NREQ-1:0]    o_ack,
    output logic [31:0]        o_rdata,
    output logic               o_err,
    output logic [31:0]        o_paddr,
    output logic [15:0]        o_psel,
    output logic               o_penable,
    output logic               o_pwrite,
    output logic [31:0]        o_pwdata,
    input  logic [31:0]        i_prdata,
    input  logic               i_pready,
    input  logic               i_pslverr
);

    // Requester index width and wait-counter width (both at least 1 bit).
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    // Value of the wait counter during the last permitted ACCESS cycle.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [IW-1:0]   r_rr;          // first index searched at the next grant
    logic [IW-1:0]   r_owner;       // requester that owns the transfer in flight
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;       // already forced to 0 for reads
    logic            r_write;
    logic [CW-1:0]   r_wait_cnt;    // PREADY-low ACCESS cycles so far
    logic [NREQ-1:0] r_ack;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [NREQ-1:0] w_eligible;
    logic            w_win_valid;
    logic [IW-1:0]   w_win_idx;
    logic [IW:0]     w_scan_idx;    // one extra bit so RR+k can exceed NREQ-1 before wrapping
    logic [NREQ-1:0] w_owner_onehot;
    logic            w_access_ok;
    logic            w_timeout;
    logic            w_grant_now;

    assign w_owner_onehot = NREQ'(1) << r_owner;
    assign w_grant_now    = (r_state == ST_IDLE) && w_win_valid;

    assign o_ack   = r_ack;
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

    // Round-robin search: first eligible index starting at r_rr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave one
        // unassigned and infer a latch.
        w_eligible  = i_req & ~r_ack;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = {1'b0, r_rr} + (IW + 1)'(k);
            if (w_scan_idx >= (IW + 1)'(NREQ)) begin
                w_scan_idx = w_scan_idx - (IW + 1)'(NREQ);
            end
            if (!w_win_valid && w_eligible[w_scan_idx[IW-1:0]]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_scan_idx[IW-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of block ordering.
        if (i_preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and APB/grant outputs; the bus is driven only while a transfer is owned.
    always_comb begin
        w_state_next = r_state;
        w_access_ok  = 1'b0;
        w_timeout    = 1'b0;
        o_grant      = '0;
        o_psel       = '0;
        o_penable    = 1'b0;
        o_paddr      = '0;
        o_pwrite     = 1'b0;
        o_pwdata     = '0;

        if (r_state != ST_IDLE) begin
            o_grant  = w_owner_onehot;
            o_psel   = 16'd1 << r_addr[27:24];
            o_paddr  = r_addr;
            o_pwrite = r_write;
            o_pwdata = r_wdata;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                o_penable = 1'b1;
                if (i_pready) begin
                    w_access_ok  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if ((TIMEOUT > 0) && (r_wait_cnt == CNT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latching, RR pointer, wait counter, and completion (ACK/RDATA/ERR) capture.
    always_ff @(posedge i_pclk) begin
        // NOTE: the datapath registers are few and drive outputs, so they are all reset;
        // that gives the all-zero output state straight out of reset.
        if (i_preset) begin
            r_rr       <= '0;
            r_owner    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_wait_cnt <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ack <= '0;

            if (w_grant_now) begin
                r_owner    <= w_win_idx;
                r_rr       <= (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
                r_addr     <= i_req_addr[32*w_win_idx +: 32];
                r_write    <= i_req_write[w_win_idx];
                r_wdata    <= i_req_write[w_win_idx] ? i_req_wdata[32*w_win_idx +: 32] : '0;
                r_wait_cnt <= '0;
            end

            if (r_state == ST_ACCESS) begin
                if (!i_pready && (r_wait_cnt != CNT_MAX)) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (w_access_ok) begin
                    r_ack   <= w_owner_onehot;
                    r_rdata <= r_write ? '0 : i_prdata;
                    r_err   <= i_pslverr;
                end else if (w_timeout) begin
                    r_ack   <= w_owner_onehot;
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
// Directed bench: single write, read with wait states, round-robin with all
// requesters active, PREADY timeout, PSLVERR, and reset mid-transfer.
// Completions are scoreboarded: expected ACK/RDATA/ERR pushed when a
// request is driven, popped when the DUT pulses ACK.
module tb_apb_master_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [31:0]     rdata;
        logic            err;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [32*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    ack;
    logic [31:0]        rdata;
    logic               err;
    logic [31:0]        paddr;
    logic [15:0]        psel;
    logic               penable;
    logic               pwrite;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    apb_master_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_pclk      (clk),
        .i_preset    (rst),
        .i_req       (req),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_grant     (grant),
        .o_ack       (ack),
        .o_rdata     (rdata),
        .o_err       (err),
        .o_paddr     (paddr),
        .o_psel      (psel),
        .o_penable   (penable),
        .o_pwrite    (pwrite),
        .o_pwdata    (pwdata),
        .i_prdata    (prdata),
        .i_pready    (pready),
        .i_pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge: outputs of the new cycle are settled,
    // and inputs driven now are sampled at the following rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i]          = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] rd, input logic e);
        exp_t x;
        x.ack   = NREQ'(1) << idx;
        x.rdata = rd;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic check_ack(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            check({tag, "_ack"},   32'(ack),   32'(x.ack));
            check({tag, "_rdata"}, rdata,      x.rdata);
            check({tag, "_err"},   32'(err),   32'(x.err));
        end
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, "_grant"},   32'(grant),   32'd0);
        check({tag, "_psel"},    32'(psel),    32'd0);
        check({tag, "_penable"}, 32'(penable), 32'd0);
        check({tag, "_paddr"},   paddr,        32'd0);
        check({tag, "_pwrite"},  32'(pwrite),  32'd0);
        check({tag, "_pwdata"},  pwdata,       32'd0);
    endtask

    // Tick until ACK appears or the budget runs out; counts ACCESS cycles seen.
    task automatic wait_ack(input int budget, output int acc_cycles);
        int n;
        n          = 0;
        acc_cycles = 0;
        while (ack == '0 && n < budget) begin
            if (penable) acc_cycles++;
            tick();
            n++;
        end
        check("ack_within_budget", 32'(ack != '0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;

        rst       = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) tick();

        // Reset state
        check_bus_idle("rst");
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_rdata", rdata,    32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Single write from requester 1, no wait states
        set_req(1, 1'b1, 32'h0300_0008, 32'hA5A5_0001);
        req    = 4'b0010;
        pready = 1'b1;
        push_exp(1, 32'h0, 1'b0);
        tick();                                     // SETUP
        check("t1_setup_psel",    32'(psel),    32'h0008);
        check("t1_setup_penable", 32'(penable), 32'd0);
        check("t1_setup_grant",   32'(grant),   32'b0010);
        check("t1_setup_paddr",   paddr,        32'h0300_0008);
        check("t1_setup_pwrite",  32'(pwrite),  32'd1);
        check("t1_setup_pwdata",  pwdata,       32'hA5A5_0001);
        req = '0;
        set_req(1, 1'b0, 32'hFFFF_FFFF, 32'h0);     // must not affect the transfer in flight
        tick();                                     // ACCESS
        check("t1_access_psel",    32'(psel),    32'h0008);
        check("t1_access_penable", 32'(penable), 32'd1);
        check("t1_access_paddr",   paddr,        32'h0300_0008);
        check("t1_access_pwdata",  pwdata,       32'hA5A5_0001);
        check("t1_access_pwrite",  32'(pwrite),  32'd1);
        tick();                                     // ACK
        check_ack("t1");
        check_bus_idle("t1_ackcyc");
        tick();
        check("t1_ack_single", 32'(ack), 32'd0);

        // Read with 3 wait states from requester 0; PSLVERR ignored while PREADY low
        set_req(0, 1'b0, 32'h0000_0004, 32'h7777_7777);
        req     = 4'b0001;
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_BEEF;
        push_exp(0, 32'h1234_5678, 1'b0);
        tick();                                     // SETUP
        check("t2_setup_psel",   32'(psel),   32'h0001);
        check("t2_setup_grant",  32'(grant),  32'b0001);
        check("t2_setup_pwdata", pwdata,      32'd0);
        check("t2_setup_pwrite", 32'(pwrite), 32'd0);
        req = '0;
        for (int c = 0; c < 4; c++) begin
            tick();                                 // ACCESS c+1
            if (c == 3) begin
                pready  = 1'b1;
                pslverr = 1'b0;
                prdata  = 32'h1234_5678;
            end
            check($sformatf("t2_access%0d_penable", c), 32'(penable), 32'd1);
            check($sformatf("t2_access%0d_paddr", c),   paddr,        32'h0000_0004);
        end
        tick();
        check_ack("t2");
        check("t2_ack_penable", 32'(penable), 32'd0);
        tick();

        // Timeout: PREADY stuck low, requester 3
        set_req(3, 1'b0, 32'h0F00_0010, 32'h0);
        req    = 4'b1000;
        pready = 1'b0;
        prdata = 32'hBAD0_BAD0;
        push_exp(3, 32'h0, 1'b1);
        tick();                                     // SETUP
        check("t3_setup_psel",  32'(psel),  32'h8000);
        check("t3_setup_grant", 32'(grant), 32'b1000);
        req = '0;
        tick();                                     // ACCESS 1
        wait_ack(64, n);
        check("t3_access_cycles", 32'(n), 32'(TIMEOUT));
        check_ack("t3");
        tick();

        // Slave error on a write from requester 2
        set_req(2, 1'b1, 32'h0100_0020, 32'h0000_BEEF);
        req     = 4'b0100;
        pready  = 1'b1;
        pslverr = 1'b1;
        push_exp(2, 32'h0, 1'b1);
        tick();                                     // SETUP
        check("t4_setup_psel",  32'(psel),  32'h0002);
        check("t4_setup_grant", 32'(grant), 32'b0100);
        req = '0;
        tick();                                     // ACCESS
        check("t4_access_penable", 32'(penable), 32'd1);
        tick();
        check_ack("t4");
        pslverr = 1'b0;
        tick();

        // All four requesters held high after reset: order 0,1,2,3,0 at a 3-cycle period
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, (i % 2) == 1, 32'h0400_0100 + (i << 24) + i * 4, 32'h1000_0000 + i);
        end
        req    = 4'b1111;
        pready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % NREQ;
            push_exp(g, ((g % 2) == 1) ? 32'h0 : 32'hC0DE_0000 + k, 1'b0);
            tick();                                 // SETUP
            check($sformatf("t5_k%0d_setup_grant", k),   32'(grant),   32'(NREQ'(1) << g));
            check($sformatf("t5_k%0d_setup_psel", k),    32'(psel),    32'(16'd1 << (4 + g)));
            check($sformatf("t5_k%0d_setup_penable", k), 32'(penable), 32'd0);
            prdata = 32'hC0DE_0000 + k;
            tick();                                 // ACCESS
            check($sformatf("t5_k%0d_access_grant", k), 32'(grant), 32'(NREQ'(1) << g));
            if (k == 4) req = '0;
            tick();                                 // ACK, next grant decision
            check_ack($sformatf("t5_k%0d", k));
            check($sformatf("t5_k%0d_ack_grant", k), 32'(grant), 32'd0);
        end
        tick();
        check("t5_idle_grant", 32'(grant), 32'd0);

        // Reset during ACCESS of requester 2
        set_req(2, 1'b1, 32'h0200_0040, 32'h5555_AAAA);
        req    = 4'b0100;
        pready = 1'b0;
        tick();                                     // SETUP
        check("t6_setup_grant", 32'(grant), 32'b0100);
        tick();                                     // ACCESS
        check("t6_access_penable", 32'(penable), 32'd1);
        rst = 1'b1;
        tick();
        check_bus_idle("t6_rst");
        check("t6_rst_ack",   32'(ack), 32'd0);
        check("t6_rst_rdata", rdata,    32'd0);
        check("t6_rst_err",   32'(err), 32'd0);
        set_req(0, 1'b0, 32'h0000_0080, 32'h0);
        req    = 4'b0101;
        rst    = 1'b0;
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        push_exp(0, 32'h0BAD_F00D, 1'b0);
        tick();                                     // SETUP
        check("t6_first_grant", 32'(grant), 32'b0001);
        tick();                                     // ACCESS
        tick();
        check_ack("t6_r0");
        check("t6_r0_no_ack2", 32'(ack & 4'b0100), 32'd0);
        push_exp(2, 32'h0, 1'b0);
        req = 4'b0100;
        tick();                                     // SETUP for requester 2
        check("t6_second_grant", 32'(grant), 32'b0100);
        req = '0;
        tick();
        tick();
        check_ack("t6_r2");

        // RR must return to 0 on reset even when it pointed past requester 0
        set_req(1, 1'b1, 32'h0100_0000, 32'h1);
        req = 4'b0010;
        push_exp(1, 32'h0, 1'b0);
        tick();
        check("t7_grant1", 32'(grant), 32'b0010);
        req = '0;
        tick();
        tick();
        check_ack("t7_r1");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0101;
        push_exp(0, 32'h0BAD_F00D, 1'b0);
        tick();
        check("t7_grant_after_rst", 32'(grant), 32'b0001);
        req = '0;
        tick();
        tick();
        check_ack("t7_r0");
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
